pbkdf2_hmac512: RTL and testbench

- Iteration controller on the initiator side of the hmac handshake. Computes one 512-bit PBKDF2-HMAC-SHA512 output block T_i = U_1 ^ U_2 ^ ... ^ U_c.
- Drives the existing hmac core: active-low restart on the core's reset, waits for core done, selects the message mode and captures oH. Runs this loop for c iterations.
- Sits between the top-level key-derivation sequencer (one start per output block) and the hmac core.

---
 rtl/hmac_pkg.sv | 21 ++
 rtl/pbkdf2_hmac512.sv | 137 +++++++++++++
 tb/tb_pbkdf2_hmac512.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/hmac_pkg.sv
// Shared types and message-layout constants for the PBKDF2 iteration controller
// and the HMAC-SHA512 core interface.
package hmac_pkg;

   localparam int unsigned KEY_W      = 1024;
   localparam int unsigned DIGEST_W   = 512;
   localparam int unsigned MSG_SALT_W = 256;
   localparam int unsigned MSG_IDX_W  = 32;
   localparam int unsigned MSG_PAD_W  = 224;

   localparam logic HMAC_MODE_SHORT = 1'b0;
   localparam logic HMAC_MODE_LONG  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_KICK,
      ST_RUN,
      ST_DONE
   } pbkdf2_state_e;

endpackage

// File: rtl/pbkdf2_hmac512.sv
// PBKDF2-HMAC-SHA512 iteration controller: restarts the HMAC core once per
// iteration, chains U through the core and XOR-accumulates T = U_1 ^ ... ^ U_c.
module pbkdf2_hmac512
   import hmac_pkg::*;
#(
   parameter int unsigned ITER_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [KEY_W-1:0]      key,
   input  logic [MSG_SALT_W-1:0] salt,
   input  logic [MSG_IDX_W-1:0]  blk_idx,
   input  logic [ITER_W-1:0]     iters,
   output logic                  busy,
   output logic                  done,
   output logic [DIGEST_W-1:0]   dk,
   output logic                  hmac_rst_n,
   output logic                  hmac_mode,
   output logic [KEY_W-1:0]      hmac_key,
   output logic [DIGEST_W-1:0]   hmac_msg,
   input  logic                  hmac_done,
   input  logic [DIGEST_W-1:0]   hmac_oH
);

   pbkdf2_state_e         state_q, state_d;
   logic [KEY_W-1:0]      key_q, key_d;
   logic [MSG_SALT_W-1:0] salt_q, salt_d;
   logic [MSG_IDX_W-1:0]  idx_q, idx_d;
   logic [ITER_W-1:0]     iters_q, iters_d;
   logic [ITER_W-1:0]     cnt_q, cnt_d;
   logic [ITER_W-1:0]     cnt_inc;
   logic [DIGEST_W-1:0]   u_q, u_d;
   logic [DIGEST_W-1:0]   t_q, t_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  rst_n_q, rst_n_d;
   logic                  mode_q, mode_d;

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      salt_d  = salt_q;
      idx_d   = idx_q;
      iters_d = iters_q;
      cnt_d   = cnt_q;
      u_d     = u_q;
      t_d     = t_q;
      busy_d  = busy_q;
      done_d  = done_q;
      rst_n_d = rst_n_q;
      mode_d  = mode_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               key_d   = key;
               salt_d  = salt;
               idx_d   = blk_idx;
               // A zero count runs the core once, exactly like a count of one.
               iters_d = (iters == '0) ? {{(ITER_W-1){1'b0}}, 1'b1} : iters;
               cnt_d   = '0;
               t_d     = '0;
               mode_d  = HMAC_MODE_SHORT;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               rst_n_d = 1'b0;
               state_d = ST_KICK;
            end
         end
         ST_KICK: begin
            rst_n_d = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (hmac_done) begin
               u_d     = hmac_oH;
               t_d     = (cnt_q == '0) ? hmac_oH : (t_q ^ hmac_oH);
               cnt_d   = cnt_inc;
               rst_n_d = 1'b0;
               if (cnt_inc == iters_q) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  mode_d  = HMAC_MODE_LONG;
                  state_d = ST_KICK;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         salt_q  <= '0;
         idx_q   <= '0;
         iters_q <= '0;
         cnt_q   <= '0;
         u_q     <= '0;
         t_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rst_n_q <= 1'b0;
         mode_q  <= HMAC_MODE_SHORT;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         salt_q  <= salt_d;
         idx_q   <= idx_d;
         iters_q <= iters_d;
         cnt_q   <= cnt_d;
         u_q     <= u_d;
         t_q     <= t_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rst_n_q <= rst_n_d;
         mode_q  <= mode_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign dk         = t_q;
   assign hmac_rst_n = rst_n_q;
   assign hmac_mode  = mode_q;
   assign hmac_key   = key_q;
   // Mux of registered state only; stable for the whole of each core run.
   assign hmac_msg   = (mode_q == HMAC_MODE_LONG) ? u_q
                                                  : {salt_q, idx_q, {MSG_PAD_W{1'b0}}};

endmodule

// File: tb/tb_pbkdf2_hmac512.sv
// Bench for pbkdf2_hmac512 against a stub HMAC core with programmable done
// latency and a simple invertible-ish mixing function in place of SHA512.
module tb_pbkdf2_hmac512;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [1023:0]  key;
   logic [255:0]   salt;
   logic [31:0]    blk_idx;
   logic [31:0]    iters;
   logic           busy;
   logic           done;
   logic [511:0]   dk;
   logic           hmac_rst_n;
   logic           hmac_mode;
   logic [1023:0]  hmac_key;
   logic [511:0]   hmac_msg;
   logic           hmac_done;
   logic [511:0]   hmac_oH;

   int n_vec;
   int n_err;

   pbkdf2_hmac512 #(.ITER_W(32)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .start      (start),
      .key        (key),
      .salt       (salt),
      .blk_idx    (blk_idx),
      .iters      (iters),
      .busy       (busy),
      .done       (done),
      .dk         (dk),
      .hmac_rst_n (hmac_rst_n),
      .hmac_mode  (hmac_mode),
      .hmac_key   (hmac_key),
      .hmac_msg   (hmac_msg),
      .hmac_done  (hmac_done),
      .hmac_oH    (hmac_oH)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [511:0] stub_f(logic [511:0] m, logic md, logic [1023:0] k);
      return {m[510:0], m[511]} ^ k[1023:512] ^ k[511:0] ^
             (md ? {16{32'h9E37_79B9}} : {16{32'h7F4A_7C15}});
   endfunction

   // Stub core: done rises lat cycles into a run, counted from its reset release.
   int stub_lat;
   int stub_cnt;
   always @(posedge clk or negedge hmac_rst_n) begin
      if (!hmac_rst_n) stub_cnt <= 0;
      else if (stub_cnt < stub_lat - 1) stub_cnt <= stub_cnt + 1;
   end
   assign hmac_done = hmac_rst_n && (stub_cnt == stub_lat - 1);
   assign hmac_oH   = stub_f(hmac_msg, hmac_mode, hmac_key);

   // Core restarts seen, and restarts whose mode was wrong (first short, rest long).
   int runs;
   int mode_err;
   always @(posedge hmac_rst_n) begin
      if (hmac_mode !== (runs > 0)) mode_err = mode_err + 1;
      runs = runs + 1;
   end

   function automatic logic [511:0] model_t(logic [1023:0] k, logic [255:0] s,
                                            logic [31:0] idx, logic [31:0] c_in);
      logic [511:0] u, t;
      int unsigned c;
      c = (c_in == 0) ? 1 : c_in;
      u = stub_f({s, idx, 224'b0}, 1'b0, k);
      t = u;
      for (int unsigned j = 1; j < c; j++) begin
         u = stub_f(u, 1'b1, k);
         t = t ^ u;
      end
      return t;
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic wait_done(input int limit, inout int cyc);
      while (done !== 1'b1 && cyc < limit) begin
         @(posedge clk);
         cyc = cyc + 1;
         #1;
      end
   endtask

   typedef struct {
      logic [1023:0] key;
      logic [255:0]  salt;
      logic [31:0]   idx;
      logic [31:0]   iters;
      int            lat;
      int            exp_cyc;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [1023:0] k_pw;
      logic [255:0]  s_seq;
      logic [255:0]  s_alt;
      logic [511:0]  exp_a;
      logic [511:0]  exp_b;
      int            cyc;
      vec_t          v;

      n_vec = 0; n_err = 0;
      runs = 0; mode_err = 0;
      stub_lat = 1;
      rst_n = 1'b0; start = 1'b0;
      key = '0; salt = '0; blk_idx = '0; iters = '0;

      k_pw  = {64'h7061_7373_776f_7264, 960'b0};
      s_seq = 256'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f_1011_1213_1415_1617_1819_1a1b_1c1d_1e1f;
      s_alt = 256'hdead_beef_0123_4567_89ab_cdef_fedc_ba98_7654_3210_5555_aaaa_0f0f_f0f0_1234_5678;

      vecs[0] = '{k_pw, s_seq, 32'd1, 32'd1,    1,   3};
      vecs[1] = '{k_pw, s_seq, 32'd1, 32'd0,    1,   3};
      vecs[2] = '{k_pw, s_alt, 32'd2, 32'd3,    2,   10};
      vecs[3] = '{~k_pw, s_seq, 32'd7, 32'd2,   200, 403};
      vecs[4] = '{k_pw, s_seq, 32'd1, 32'd4096, 1,   8193};
      vecs[5] = '{{16{64'h0123_4567_89ab_cdef}}, s_alt, 32'hffff_ffff, 32'd5, 3, 21};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy",  {511'b0, busy},       '0);
      chk("reset_done",  {511'b0, done},       '0);
      chk("reset_dk",    dk,                   '0);
      chk("reset_rst_n", {511'b0, hmac_rst_n}, '0);
      chk("reset_mode",  {511'b0, hmac_mode},  '0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         stub_lat = v.lat;
         runs = 0; mode_err = 0;
         @(negedge clk);
         key = v.key; salt = v.salt; blk_idx = v.idx; iters = v.iters; start = 1'b1;
         @(posedge clk);
         cyc = 1;
         #1;
         start = 1'b0;
         key = ~v.key; salt = ~v.salt; blk_idx = ~v.idx; iters = 32'd9;
         chk($sformatf("v%0d_busy_after_start", i), {511'b0, busy}, {511'b0, 1'b1});
         wait_done(v.exp_cyc + 50, cyc);
         chk($sformatf("v%0d_dk", i), dk, model_t(v.key, v.salt, v.idx, v.iters));
         chk($sformatf("v%0d_cycles", i), 512'(cyc), 512'(v.exp_cyc));
         chk($sformatf("v%0d_runs", i), 512'(runs), 512'((v.iters == 0) ? 1 : v.iters));
         chk($sformatf("v%0d_mode_err", i), 512'(mode_err), '0);
         chk($sformatf("v%0d_done_idle", i), {510'b0, busy, hmac_rst_n}, '0);
         chk($sformatf("v%0d_hmac_key", i), hmac_key[1023:512] ^ hmac_key[511:0],
             v.key[1023:512] ^ v.key[511:0]);
      end

      // start held high throughout a c=3 run with a different salt each cycle
      stub_lat = 4;
      runs = 0; mode_err = 0;
      exp_a = model_t(k_pw, s_seq, 32'd1, 32'd3);
      exp_b = model_t(k_pw, s_alt, 32'd1, 32'd2);
      @(negedge clk);
      key = k_pw; salt = s_seq; blk_idx = 32'd1; iters = 32'd3; start = 1'b1;
      @(posedge clk);
      cyc = 1;
      #1;
      salt = s_alt; iters = 32'd2;
      wait_done(200, cyc);
      chk("spam_dk", dk, exp_a);
      chk("spam_cycles", 512'(cyc), 512'(16));
      chk("spam_runs", 512'(runs), 512'(3));
      @(posedge clk);
      #1;
      chk("spam_restart_done_drop", {510'b0, done, busy}, {510'b0, 1'b0, 1'b1});
      start = 1'b0;
      cyc = 1;
      wait_done(200, cyc);
      chk("spam_second_dk", dk, exp_b);

      // asynchronous reset in the middle of the second core run
      stub_lat = 5;
      runs = 0; mode_err = 0;
      @(negedge clk);
      key = k_pw; salt = s_seq; blk_idx = 32'd1; iters = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (runs < 2 && cyc < 200) begin
         @(posedge clk);
         cyc = cyc + 1;
      end
      chk("midrst_reached_run2", 512'(runs), 512'(2));
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy",  {511'b0, busy},       '0);
      chk("midrst_done",  {511'b0, done},       '0);
      chk("midrst_dk",    dk,                   '0);
      chk("midrst_rst_n", {511'b0, hmac_rst_n}, '0);
      @(negedge clk) rst_n = 1'b1;

      runs = 0; mode_err = 0;
      stub_lat = 3;
      @(negedge clk);
      key = k_pw; salt = s_alt; blk_idx = 32'd4; iters = 32'd2; start = 1'b1;
      @(posedge clk);
      cyc = 1;
      #1;
      start = 1'b0;
      wait_done(100, cyc);
      chk("postrst_dk", dk, model_t(k_pw, s_alt, 32'd4, 32'd2));
      chk("postrst_cycles", 512'(cyc), 512'(9));
      chk("postrst_mode_err", 512'(mode_err), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
